// File: rtl/fft_sequencer.sv
// Issue sequencer for an in-place radix-2 FFT: walks stage-major / pair-ascending
// butterfly issue and drains outstanding write-backs between stages.
module fft_sequencer #(
   parameter int N             = 32,
   parameter int stage_width   = $clog2($clog2(N)),
   parameter int pair_id_width = $clog2(N/2),
   parameter int cnt_width     = $clog2(N/2+1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stall,
   input  logic                     wb_valid,
   output logic                     agu_valid,
   output logic [stage_width-1:0]   stage,
   output logic [pair_id_width-1:0] pair_id,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int LOG2N = $clog2(N);
   localparam logic [stage_width-1:0]   LAST_STAGE = stage_width'(LOG2N-1);
   localparam logic [pair_id_width-1:0] LAST_PAIR  = pair_id_width'(N/2-1);
   localparam logic [cnt_width-1:0]     MAX_OUT    = cnt_width'(N/2);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [stage_width-1:0]   stg_cnt_q, stg_cnt_d;
   logic [pair_id_width-1:0] pair_cnt_q, pair_cnt_d;
   logic                     agu_valid_q, agu_valid_d;
   logic [stage_width-1:0]   stage_q, stage_d;
   logic [pair_id_width-1:0] pair_id_q, pair_id_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic [cnt_width-1:0]     outst_q, outst_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         stg_cnt_q   <= '0;
         pair_cnt_q  <= '0;
         agu_valid_q <= 1'b0;
         stage_q     <= '0;
         pair_id_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         outst_q     <= '0;
      end else begin
         state_q     <= state_d;
         stg_cnt_q   <= stg_cnt_d;
         pair_cnt_q  <= pair_cnt_d;
         agu_valid_q <= agu_valid_d;
         stage_q     <= stage_d;
         pair_id_q   <= pair_id_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         outst_q     <= outst_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stg_cnt_d   = stg_cnt_q;
      pair_cnt_d  = pair_cnt_q;
      agu_valid_d = 1'b0;
      stage_d     = stage_q;
      pair_id_d   = pair_id_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      outst_d     = outst_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_ISSUE;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               stg_cnt_d  = '0;
               pair_cnt_d = '0;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               agu_valid_d = 1'b1;
               stage_d     = stg_cnt_q;
               pair_id_d   = pair_cnt_q;
               if (pair_cnt_q == LAST_PAIR) state_d = S_DRAIN;
               else pair_cnt_d = pair_cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // agu_valid_q covers the final issue not yet reflected in outst_q
            if (outst_q == '0 && !agu_valid_q) begin
               if (stg_cnt_q < LAST_STAGE) begin
                  stg_cnt_d  = stg_cnt_q + 1'b1;
                  pair_cnt_d = '0;
                  state_d    = S_ISSUE;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Write-back error wins over the start-time clear so a stray wb is never lost
      case ({agu_valid_q, wb_valid})
         2'b10: if (outst_q != MAX_OUT) outst_d = outst_q + 1'b1;
         2'b01: begin
            if (outst_q != '0) outst_d = outst_q - 1'b1;
            else err_d = 1'b1;
         end
         default: outst_d = outst_q;
      endcase
   end

   assign agu_valid = agu_valid_q;
   assign stage     = stage_q;
   assign pair_id   = pair_id_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
